hilbert_seq: RTL
================

Name: hilbert_seq

Overview:
Sequencer and output scheduler for the Hilbert FIR datapath. It replaces the filter's free-running internal cadence with a controlled run state machine: start/stop, a pipeline clear, a one-cycle step strobe every CADENCE clocks, and suppression of outputs until the pipeline is primed. It captures the filter's Re/Im outputs into a single-entry valid/ready output register and counts samples lost to downstream back-pressure.

Parameters:
CADENCE, 20, clocks per input sample; legal range 3..255.
ORDER, 4, number of steps needed to fill the filter pipeline before its output is meaningful.
DW, 13, width of Re/Im samples.

Ports:
clock  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
start  in  1  level, sampled each clock; begins a run from IDLE.
stop  in  1  level, sampled each clock; ends a run and returns to IDLE.
re_in  in  DW  signed Re from filter, registered in the filter.
im_in  in  DW  signed Im from filter, registered in the filter.
fir_step  out  1  one-cycle strobe; the filter shifts and accumulates one sample.
fir_clear  out  1  one-cycle synchronous clear of the filter registers.
out_re  out  DW  captured Re.
out_im  out  DW  captured Im.
out_valid  out  1  out_re/out_im hold an unconsumed sample.
out_ready  in  1  downstream accepts the sample when out_valid&&out_ready.
busy  out  1  high in FLUSH, FILL and RUN.
primed  out  1  high in RUN.
overrun  out  1  sticky; a sample was dropped.
overrun_cnt  out  8  count of dropped samples; saturates at 255.
clr_overrun  in  1  synchronous clear of overrun and overrun_cnt.

Behaviour:
- Reset (async): state=IDLE; cnt=CADENCE-1; fill_cnt=0; step_d=0. All outputs are 0, including out_re/out_im.
- States are IDLE, FLUSH, FILL and RUN.
- IDLE: start=1 goes to FLUSH. stop has priority when start=1 and stop=1 in the same cycle.
- FLUSH (exactly 1 cycle): fir_clear=1; cnt is loaded with CADENCE-1; fill_cnt is loaded with 0; next state is FILL.
- FILL/RUN cadence: cnt decrements each cycle. When cnt==0, fir_step=1 for that cycle and cnt reloads to CADENCE-1. fir_step is never asserted in consecutive cycles.
- FILL: each fir_step increments fill_cnt. The ORDER-th step moves to RUN on the same edge.
- Capture: step_d is fir_step delayed one cycle. When step_d=1 and state==RUN, re_in/im_in are offered to the output register. The first offer is the cycle after the ORDER-th step.
- Output register, on an offer:
  - Register empty, or consumed in the same cycle (out_valid&&out_ready): load the sample; out_valid=1.
  - Register full and not consumed: discard the new sample and keep the old one; overrun=1; overrun_cnt+1, saturating.
- Without an offer, out_valid&&out_ready clears out_valid. out_re/out_im keep their last value.
- stop in FLUSH/FILL/RUN: next state is IDLE, and fir_step is suppressed in the cycle stop is sampled. An offer pending from step_d is discarded. Any held output stays valid until consumed.
- start while busy is ignored. A re-start always passes through FLUSH again.
- clr_overrun has priority over an increment in the same cycle.
- Reset mid-run aborts immediately; no fir_clear is issued, so the next start performs the clear.

Test Plan:
- Reset then idle: all outputs 0; fir_step never asserts for 100 cycles.
- start pulse sampled at edge t0, out_ready=1:
  - fir_clear high in cycle t0+1.
  - fir_step high in cycles t0+21, t0+41, t0+61, t0+81 and every 20 cycles after.
  - primed rises at t0+82.
  - out_valid first high in cycle t0+83, holding the re_in/im_in value driven in cycle t0+82, e.g. re=-4096, im=4095.
- out_ready=0 across 3 offers: first sample is held unchanged; overrun=1; overrun_cnt=2. With out_ready=1 on the offer cycle of the next sample: that sample is loaded, out_valid stays 1, and there is no increment.
- stop asserted in a cycle where cnt==0: no fir_step in that cycle; state is IDLE next cycle; busy=0; a held out_valid remains until out_ready.
- start and stop both high in IDLE: no transition. start while in RUN: no FLUSH and the step phase is unchanged.
- Async reset asserted mid-RUN between edges: all outputs drop to 0 immediately. Force overrun_cnt to 255 with further drops: it stays 255. clr_overrun coincident with a drop: result is 0.

Source files
------------

// File: rtl/hilbert_seq.sv
// hilbert_seq: run sequencer and valid/ready output scheduler for the Hilbert FIR datapath
module hilbert_seq #(
    parameter int CADENCE = 20,
    parameter int ORDER   = 4,
    parameter int DW      = 13
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [DW-1:0] re_in,
    input  logic [DW-1:0] im_in,
    output logic          fir_step,
    output logic          fir_clear,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          primed,
    output logic          overrun,
    output logic [7:0]    overrun_cnt,
    input  logic          clr_overrun
);
    localparam int FW = $clog2(ORDER + 1);
    typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} state_t;
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic          step_dly_q, step_dly_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    overrun_cnt_q, overrun_cnt_d;
    logic          active, offer, take, drop;
    always_comb begin
        active     = state_q == FILL || state_q == RUN;
        fir_step   = active && cnt_q == 8'd0 && !stop;
        fir_clear  = state_q == FLUSH;
        busy       = state_q != IDLE;
        primed     = state_q == RUN;
        offer      = step_dly_q && state_q == RUN && !stop;
        take       = offer && (!out_valid_q || out_ready);
        drop       = offer && out_valid_q && !out_ready;
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_cnt_d = fill_cnt_q;
        step_dly_d = fir_step;
        if (stop) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = start ? FLUSH : IDLE;
        end else if (state_q == FLUSH) begin
            state_d    = FILL;
            cnt_d      = 8'(CADENCE - 1);
            fill_cnt_d = '0;
        end else begin
            cnt_d = cnt_q == 8'd0 ? 8'(CADENCE - 1) : cnt_q - 8'd1;
            // The ORDER-th step primes the pipeline and enters RUN on the same edge.
            if (state_q == FILL && fir_step) begin
                fill_cnt_d = fill_cnt_q + FW'(1);
                state_d    = fill_cnt_q == FW'(ORDER - 1) ? RUN : FILL;
            end
        end
        out_valid_d   = take ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        out_re_d      = take ? re_in : out_re_q;
        out_im_d      = take ? im_in : out_im_q;
        overrun_d     = clr_overrun ? 1'b0 : overrun_q | drop;
        overrun_cnt_d = clr_overrun ? 8'd0 :
                        (drop && overrun_cnt_q != 8'hff) ? overrun_cnt_q + 8'd1 : overrun_cnt_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 8'(CADENCE - 1);
            fill_cnt_q    <= '0;
            step_dly_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_re_q      <= '0;
            out_im_q      <= '0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fill_cnt_q    <= fill_cnt_d;
            step_dly_q    <= step_dly_d;
            out_valid_q   <= out_valid_d;
            out_re_q      <= out_re_d;
            out_im_q      <= out_im_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end
    assign out_valid   = out_valid_q;
    assign out_re      = out_re_q;
    assign out_im      = out_im_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;
endmodule
